// File: rtl/interp_linha_up2.sv
// interp_linha_up2: 2x linear upsampler for one 16-sample line.
// Accepts a line in a single handshake and then emits 32 samples on a valid/ready stream.
// Even outputs repeat the input samples. Odd outputs are the rounded midpoint of the two
// neighbouring inputs. The last output replicates the edge sample.
module interp_linha_up2 #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_0,
    input  logic [DATA_WIDTH-1:0] in_1,
    input  logic [DATA_WIDTH-1:0] in_2,
    input  logic [DATA_WIDTH-1:0] in_3,
    input  logic [DATA_WIDTH-1:0] in_4,
    input  logic [DATA_WIDTH-1:0] in_5,
    input  logic [DATA_WIDTH-1:0] in_6,
    input  logic [DATA_WIDTH-1:0] in_7,
    input  logic [DATA_WIDTH-1:0] in_8,
    input  logic [DATA_WIDTH-1:0] in_9,
    input  logic [DATA_WIDTH-1:0] in_10,
    input  logic [DATA_WIDTH-1:0] in_11,
    input  logic [DATA_WIDTH-1:0] in_12,
    input  logic [DATA_WIDTH-1:0] in_13,
    input  logic [DATA_WIDTH-1:0] in_14,
    input  logic [DATA_WIDTH-1:0] in_15,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [4:0]            out_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  line_done
);

    typedef enum logic [0:0] {
        StIdle,
        StEmit
    } state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] line_q  [16];
    logic [DATA_WIDTH-1:0] line_d  [16];
    logic [DATA_WIDTH-1:0] in_line [16];

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [4:0]            index_q, index_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  transfer;
    logic                  last_beat;

    logic [4:0]            next_k;
    logic [3:0]            base_idx;
    logic [3:0]            nbr_idx;
    logic [DATA_WIDTH-1:0] left_s;
    logic [DATA_WIDTH-1:0] right_s;
    logic [DATA_WIDTH:0]   pair_sum;
    logic [DATA_WIDTH-1:0] mid_s;
    logic                  unused_round_lsb;
    logic [DATA_WIDTH-1:0] next_sample;

    // Gather the flat input ports into an indexable line.
    always_comb begin
        in_line[0]  = in_0;
        in_line[1]  = in_1;
        in_line[2]  = in_2;
        in_line[3]  = in_3;
        in_line[4]  = in_4;
        in_line[5]  = in_5;
        in_line[6]  = in_6;
        in_line[7]  = in_7;
        in_line[8]  = in_8;
        in_line[9]  = in_9;
        in_line[10] = in_10;
        in_line[11] = in_11;
        in_line[12] = in_12;
        in_line[13] = in_13;
        in_line[14] = in_14;
        in_line[15] = in_15;
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StEmit);
    assign out_data  = data_q;
    assign out_index = index_q;
    assign line_done = done_q;

    assign accept    = enable & in_valid & (state_q == StIdle);
    assign transfer  = enable & out_ready & (state_q == StEmit);
    assign last_beat = (index_q == 5'd31);

    // Select the sample for index k+1 from the latched line.
    // The sum is one bit wider so that 255+255+1 cannot wrap.
    always_comb begin
        next_k   = index_q + 5'd1;
        base_idx = next_k[4:1];
        // Wraps to 0 when base_idx is 15; that case takes the edge-replicate branch below.
        nbr_idx  = base_idx + 4'd1;
        left_s   = line_q[base_idx];
        right_s  = line_q[nbr_idx];
        pair_sum = {1'b0, left_s} + {1'b0, right_s} + {{DATA_WIDTH{1'b0}}, 1'b1};
        {mid_s, unused_round_lsb} = pair_sum;
        if (!next_k[0] || (base_idx == 4'hF)) begin
            next_sample = left_s;
        end else begin
            next_sample = mid_s;
        end
    end

    // Next-state logic: accept a line in idle, step through the 32 outputs while emitting.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        data_d  = data_q;
        index_d = index_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    line_d  = in_line;
                    data_d  = in_0;
                    index_d = 5'd0;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (transfer) begin
                    if (last_beat) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        index_d = next_k;
                        data_d  = next_sample;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers. An asynchronous reset drops any line in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            line_q  <= '{default: '0};
            data_q  <= '0;
            index_q <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            data_q  <= data_d;
            index_q <= index_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_interp_linha_up2.sv
// Directed bench for interp_linha_up2. Inputs change on the falling edge and outputs
// are sampled there, away from the rising edge where the DUT updates.
module tb_interp_linha_up2;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x [16];
    logic [7:0] out_data;
    logic [4:0] out_index;
    logic       out_valid;
    logic       out_ready;
    logic       line_done;

    logic [7:0] exp_y [32];
    int         errors = 0;
    int         checks = 0;

    always #5 clock = ~clock;

    interp_linha_up2 #(.DATA_WIDTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_0     (x[0]),
        .in_1     (x[1]),
        .in_2     (x[2]),
        .in_3     (x[3]),
        .in_4     (x[4]),
        .in_5     (x[5]),
        .in_6     (x[6]),
        .in_7     (x[7]),
        .in_8     (x[8]),
        .in_9     (x[9]),
        .in_10    (x[10]),
        .in_11    (x[11]),
        .in_12    (x[12]),
        .in_13    (x[13]),
        .in_14    (x[14]),
        .in_15    (x[15]),
        .out_data (out_data),
        .out_index(out_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .line_done(line_done)
    );

    // Ramp line x[i]=i; y = 0,1,1,2,2,...,15,15 with y[31]=15.
    task automatic load_ramp();
        for (int i = 0; i < 16; i++) x[i] = 8'(i);
        for (int k = 0; k < 32; k++) exp_y[k] = (k == 31) ? 8'd15 : 8'((k + 1) / 2);
    endtask

    // Present the current x for one accepting edge; returns with y[0] visible.
    task automatic send_line();
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Consume the rest of a line starting at beat 'start'. mode 1 drives out_ready 1,0,0,...
    task automatic drain(input int start, input int mode, input string name);
        int         n;
        logic       stalled;
        logic [7:0] hd;
        logic [4:0] hi;
        n = start;
        stalled = 1'b0;
        hd = '0;
        hi = '0;
        for (int cyc = 0; cyc < 400 && n < 32; cyc++) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s valid beat %0d: out_valid=%b required 1", name, n, out_valid);
            end else if (stalled) begin
                checks++;
                if (out_data !== hd || out_index !== hi) begin
                    errors++;
                    $display("FAIL %s hold beat %0d: data=%0d idx=%0d required data=%0d idx=%0d",
                             name, n, out_data, out_index, hd, hi);
                end
            end
            if (out_ready) begin
                checks++;
                if (out_index !== 5'(n) || out_data !== exp_y[n]) begin
                    errors++;
                    $display("FAIL %s beat %0d: data=%0d idx=%0d required data=%0d idx=%0d",
                             name, n, out_data, out_index, exp_y[n], n);
                end
                n++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hd = out_data;
                hi = out_index;
            end
            @(negedge clock);
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL %s transfer count: got %0d required 32", name, n);
        end
        checks++;
        if (line_done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s end: line_done=%b out_valid=%b in_ready=%b required 1 0 1",
                     name, line_done, out_valid, in_ready);
        end
        @(negedge clock);
        checks++;
        if (line_done !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse width: line_done=%b required 0", name, line_done);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) x[i] = 8'd0;
        repeat (2) @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 ||
            out_index !== 5'd0 || line_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b data=%0d idx=%0d done=%b required 1 0 0 0 0",
                     in_ready, out_valid, out_data, out_index, line_done);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_ramp();
        load_ramp();
        send_line();
        drain(0, 0, "ramp");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 16; i++) x[i] = 8'd255;
        for (int k = 0; k < 32; k++) exp_y[k] = 8'd255;
        send_line();
        drain(0, 0, "all255");
        // x = 0,255,0,255,...: midpoints 128 both ways, y[31]=x[15]=255.
        for (int i = 0; i < 16; i++) x[i] = (i % 2 == 0) ? 8'd0 : 8'd255;
        for (int k = 0; k < 32; k++) begin
            if (k == 31) exp_y[k] = 8'd255;
            else if (k % 2 == 1) exp_y[k] = 8'd128;
            else exp_y[k] = ((k / 2) % 2 == 0) ? 8'd0 : 8'd255;
        end
        send_line();
        drain(0, 0, "alternate");
    endtask

    task automatic test_backpressure();
        load_ramp();
        send_line();
        drain(0, 1, "backpressure");
    endtask

    task automatic test_reset_midline();
        load_ramp();
        send_line();
        out_ready = 1'b1;
        repeat (10) @(negedge clock);
        checks++;
        if (out_index !== 5'd10 || out_data !== 8'd5) begin
            errors++;
            $display("FAIL midline pre-reset: idx=%0d data=%0d required 10 5", out_index, out_data);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 5'd0) begin
            errors++;
            $display("FAIL async reset: vld=%b rdy=%b idx=%0d required 0 1 0",
                     out_valid, in_ready, out_index);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checks++;
            if (line_done !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL no done after reset: done=%b vld=%b required 0 0",
                         line_done, out_valid);
            end
        end
        for (int i = 0; i < 16; i++) x[i] = 8'(i + 100);
        for (int k = 0; k < 32; k++) exp_y[k] = (k == 31) ? 8'd115 : 8'((k + 1) / 2 + 100);
        send_line();
        drain(0, 0, "after reset");
    endtask

    task automatic test_enable();
        load_ramp();
        send_line();
        out_ready = 1'b1;
        repeat (7) @(negedge clock);
        enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if (out_index !== 5'd7 || out_data !== 8'd4 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL enable freeze %0d: idx=%0d data=%0d vld=%b required 7 4 1",
                         c, out_index, out_data, out_valid);
            end
        end
        enable = 1'b1;
        drain(7, 0, "enable resume");
        enable = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle disabled %0d: rdy=%b vld=%b required 1 0",
                         c, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        enable = 1'b1;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle disabled accept: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        // Line A: x[i]=2i -> y[k]=k, y[31]=30.
        for (int i = 0; i < 16; i++) x[i] = 8'(2 * i);
        for (int k = 0; k < 32; k++) exp_y[k] = (k == 31) ? 8'd30 : 8'(k);
        out_ready = 1'b1;
        in_valid = 1'b1;
        @(negedge clock);
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (out_valid !== 1'b1 || out_index !== 5'(n) || out_data !== exp_y[n]) begin
                errors++;
                $display("FAIL b2b line A beat %0d: vld=%b idx=%0d data=%0d required 1 %0d %0d",
                         n, out_valid, out_index, out_data, n, exp_y[n]);
            end
            for (int j = 0; j < 16; j++) x[j] = 8'(200 + n + j);
            @(negedge clock);
        end
        checks++;
        if (line_done !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b line A done: done=%b rdy=%b required 1 1", line_done, in_ready);
        end
        // Line C, present at the accepting edge: x[i]=16i -> y[k]=8k, y[31]=240.
        for (int i = 0; i < 16; i++) x[i] = 8'(16 * i);
        for (int k = 0; k < 32; k++) exp_y[k] = (k == 31) ? 8'd240 : 8'(8 * k);
        @(negedge clock);
        in_valid = 1'b0;
        drain(0, 0, "b2b line C");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp();
        test_saturate();
        test_backpressure();
        test_reset_midline();
        test_enable();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
